// File: rtl/pr_pkg.sv
// Shared widths, phase constants and payload types for the FFT peak/phase extractor.
package pr_pkg;
  localparam int unsigned BIN_W = 11;
  localparam int unsigned MAG_W = 25;

  typedef shortint phase_t;

  localparam phase_t            PHASE_PI  = 16'sd25736;
  localparam logic signed [16:0] PHASE_2PI = 17'sd51472;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
    phase_t           phase;
  } peak_t;

  typedef enum logic {WAIT_SOP, COLLECT} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_EMIT} out_state_t;
endpackage

// File: rtl/phase_wrap.sv
// Combinational phase difference, wrapped into [-pi, pi) in Q3.13.
module phase_wrap
  import pr_pkg::*;
(
  input  phase_t phase,
  input  phase_t ref_phase,
  output phase_t dphase
);
  localparam logic signed [16:0] PI17 = 17'(PHASE_PI);

  logic signed [16:0] diff;
  logic signed [16:0] wrapped;

  always_comb begin
    diff    = 17'(phase) - 17'(ref_phase);
    wrapped = diff;
    if (diff >= PI17)       wrapped = diff - PHASE_2PI;
    else if (diff < -PI17)  wrapped = diff + PHASE_2PI;
    dphase = phase_t'(wrapped[15:0]);
  end
endmodule

// File: rtl/fft_peak_phase.sv
// Per-channel peak search over polar FFT frames; emits one result beat per
// channel with phase relative to channel 0 once a full set has been received.
module fft_peak_phase
  import pr_pkg::*;
#(
  parameter int unsigned NCH    = 3,
  parameter int unsigned POW    = BIN_W,
  parameter int unsigned MWIDTH = MAG_W,
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 1023,
  parameter int unsigned MODE   = 0
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  input  logic [MWIDTH-1:0]         sink_mag,
  input  logic [15:0]               sink_phase,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  output logic [$clog2(NCH)-1:0]    source_chan,
  output logic [POW-1:0]            source_bin,
  output logic [MWIDTH-1:0]         source_mag,
  output logic [15:0]               source_dphase,
  output logic                      error
);
  localparam int unsigned    CH_W    = $clog2(NCH);
  localparam logic [POW-1:0] BIN_MAX = '1;
  localparam logic [POW-1:0] LO      = POW'(BIN_LO);
  localparam logic [POW-1:0] HI      = POW'(BIN_HI);

  in_state_t        in_state, in_next;
  out_state_t       out_state, out_next;
  logic [POW-1:0]   bin_cnt, cur_bin;
  logic [CH_W-1:0]  ch, ochan;
  peak_t            best, base, best_nx, sel;
  peak_t            res    [NCH];
  peak_t            shadow [NCH];
  logic             take, hit, frame_ok, frame_bad, set_done;
  phase_t           wrap_d;

  assign cur_bin = sink_sop ? '0 : bin_cnt;
  assign take    = sink_valid && (in_state == COLLECT || sink_sop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_state <= WAIT_SOP;
    else       in_state <= in_next;
  end

  always_comb begin
    in_next = in_state;
    if (take) in_next = (sink_eop || cur_bin == BIN_MAX) ? WAIT_SOP : COLLECT;
  end

  // Frame-end classification and candidate peak update for the current beat.
  always_comb begin
    frame_ok  = take && sink_eop && (cur_bin == BIN_MAX);
    frame_bad = take && (sink_eop ^ (cur_bin == BIN_MAX));
    base = best;
    if (sink_sop) begin
      base.bin   = BIN_W'(LO);
      base.mag   = '0;
      base.phase = '0;
    end
    if (MODE == 1 && ch != '0) hit = (cur_bin == POW'(res[0].bin));
    else hit = (cur_bin >= LO) && (cur_bin <= HI) && (MAG_W'(sink_mag) > base.mag);
    best_nx = base;
    if (hit) begin
      best_nx.bin   = BIN_W'(cur_bin);
      best_nx.mag   = MAG_W'(sink_mag);
      best_nx.phase = phase_t'(sink_phase);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_cnt  <= '0;
      ch       <= '0;
      best     <= '0;
      error    <= 1'b0;
      set_done <= 1'b0;
      for (int k = 0; k < int'(NCH); k++) begin
        res[k]    <= '0;
        shadow[k] <= '0;
      end
    end else begin
      error    <= frame_bad;
      set_done <= 1'b0;
      if (take) begin
        best    <= best_nx;
        bin_cnt <= cur_bin + 1'b1;
        if (frame_bad) ch <= '0;
        else if (frame_ok) begin
          for (int k = 0; k < int'(NCH); k++)
            if (CH_W'(k) == ch) res[k] <= best_nx;
          if (ch == CH_W'(NCH - 1)) begin
            ch       <= '0;
            set_done <= 1'b1;
            for (int k = 0; k < int'(NCH); k++)
              shadow[k] <= (k == int'(NCH) - 1) ? best_nx : res[k];
          end else begin
            ch <= ch + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_state <= OUT_IDLE;
    else       out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      OUT_IDLE: if (set_done) out_next = OUT_EMIT;
      OUT_EMIT: if (ochan == CH_W'(NCH - 1)) out_next = OUT_IDLE;
      default:  out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    sel = shadow[0];
    for (int k = 0; k < int'(NCH); k++)
      if (CH_W'(k) == ochan) sel = shadow[k];
  end

  phase_wrap u_wrap (
    .phase     (sel.phase),
    .ref_phase (shadow[0].phase),
    .dphase    (wrap_d)
  );

  logic              valid_nx, sop_nx, eop_nx;
  logic [CH_W-1:0]   chan_nx;
  logic [POW-1:0]    bin_nx;
  logic [MWIDTH-1:0] mag_nx;
  logic [15:0]       dphase_nx;

  // Result fields hold between bursts; only valid drops.
  always_comb begin
    valid_nx  = 1'b0;
    sop_nx    = source_sop;
    eop_nx    = source_eop;
    chan_nx   = source_chan;
    bin_nx    = source_bin;
    mag_nx    = source_mag;
    dphase_nx = source_dphase;
    if (out_state == OUT_EMIT) begin
      valid_nx  = 1'b1;
      sop_nx    = (ochan == '0);
      eop_nx    = (ochan == CH_W'(NCH - 1));
      chan_nx   = ochan;
      bin_nx    = POW'(sel.bin);
      mag_nx    = MWIDTH'(sel.mag);
      dphase_nx = wrap_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ochan         <= '0;
      source_valid  <= 1'b0;
      source_sop    <= 1'b0;
      source_eop    <= 1'b0;
      source_chan   <= '0;
      source_bin    <= '0;
      source_mag    <= '0;
      source_dphase <= '0;
    end else begin
      ochan         <= (out_state == OUT_EMIT) ? ochan + 1'b1 : '0;
      source_valid  <= valid_nx;
      source_sop    <= sop_nx;
      source_eop    <= eop_nx;
      source_chan   <= chan_nx;
      source_bin    <= bin_nx;
      source_mag    <= mag_nx;
      source_dphase <= dphase_nx;
    end
  end
endmodule

// File: tb/tb_fft_peak_phase.sv
// Scoreboard bench for fft_peak_phase: a MODE 0 and a MODE 1 instance share the sink bus.
module tb_fft_peak_phase;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  chan;
    logic [10:0] bin;
    logic [24:0] mag;
    logic [15:0] dphase;
  } beat_t;

  logic        clk = 1'b0, reset = 1'b1, sel_m1 = 1'b0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [24:0] sink_mag = '0;
  logic [15:0] sink_phase = '0;

  logic        v0, sop0, eop0, err0, v1, sop1, eop1, err1;
  logic [1:0]  chan0, chan1;
  logic [10:0] bin0, bin1;
  logic [24:0] mag0, mag1;
  logic [15:0] dph0, dph1;

  fft_peak_phase #(.MODE(0)) dut (
    .clk(clk), .reset(reset), .sink_valid(sink_valid & ~sel_m1), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_mag(sink_mag), .sink_phase(sink_phase),
    .source_valid(v0), .source_sop(sop0), .source_eop(eop0), .source_chan(chan0),
    .source_bin(bin0), .source_mag(mag0), .source_dphase(dph0), .error(err0));

  fft_peak_phase #(.MODE(1)) dut_m1 (
    .clk(clk), .reset(reset), .sink_valid(sink_valid & sel_m1), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_mag(sink_mag), .sink_phase(sink_phase),
    .source_valid(v1), .source_sop(sop1), .source_eop(eop1), .source_chan(chan1),
    .source_bin(bin1), .source_mag(mag1), .source_dphase(dph1), .error(err1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;
  int err_cnt0 = 0, err_cnt1 = 0;
  int last_eop_cyc = 0;
  int zero_chk_at = -1, err_chk_at = -1, err_chk_exp = 0, end_chk_at = -1;

  task automatic push(input bit m1, input int ch, input int bin, input int mag, input int dph);
    beat_t b;
    b.sop = (ch == 0); b.eop = (ch == 2); b.chan = 2'(ch);
    b.bin = 11'(bin); b.mag = 25'(mag); b.dphase = 16'(dph);
    if (m1) q1.push_back(b); else q0.push_back(b);
  endtask

  // Beats 0..last; eop on eop_at (-1 = none); up to three special bins over a mag-10 floor.
  task automatic send_frame(input int last, input int eop_at,
                            input int b0, input int m0, input int p0,
                            input int b1, input int m1, input int p1,
                            input int b2, input int m2, input int p2, input int gap);
    for (int i = 0; i <= last; i++) begin
      if (gap > 0)
        while ($urandom_range(99, 0) < gap) begin
          sink_valid = 1'b0; @(posedge clk); #1;
        end
      sink_valid = 1'b1; sink_sop = (i == 0); sink_eop = (i == eop_at);
      sink_mag = 25'd10; sink_phase = 16'd7;
      if (i == b0) begin sink_mag = 25'(m0); sink_phase = 16'(p0); end
      if (i == b1) begin sink_mag = 25'(m1); sink_phase = 16'(p1); end
      if (i == b2) begin sink_mag = 25'(m2); sink_phase = 16'(p2); end
      @(posedge clk); #1;
      if (i == eop_at) last_eop_cyc = cyc;
    end
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic full(input int b0, input int m0, input int p0, input int b1, input int m1,
                      input int p1, input int b2, input int m2, input int p2, input int gap);
    send_frame(2047, 2047, b0, m0, p0, b1, m1, p1, b2, m2, p2, gap);
  endtask

  task automatic check_beat(input int id, input beat_t a, input int q_len, input beat_t e);
    n_cmp++;
    if (q_len == 0) begin
      n_bad++;
      $display("FAIL out%0d_unexpected: got chan %0d bin %0d mag %0d, required no beat", id, a.chan, a.bin, a.mag);
    end else if (a !== e) begin
      n_bad++;
      $display("FAIL out%0d_beat: got sop %0b eop %0b chan %0d bin %0d mag %0d dphase %0d, required sop %0b eop %0b chan %0d bin %0d mag %0d dphase %0d",
               id, a.sop, a.eop, a.chan, a.bin, a.mag, $signed(a.dphase),
               e.sop, e.eop, e.chan, e.bin, e.mag, $signed(e.dphase));
    end
    if (a.sop) begin
      n_cmp++;
      if (cyc - last_eop_cyc != 2) begin
        n_bad++;
        $display("FAIL out%0d_latency: got %0d cycles, required 2", id, cyc - last_eop_cyc);
      end
    end
  endtask

  // Monitor: all comparisons happen here, away from the active edge.
  always @(negedge clk) begin
    beat_t a, e;
    int    len;
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
    if (v0) begin
      a = {sop0, eop0, chan0, bin0, mag0, dph0};
      len = q0.size(); e = '0;
      if (len != 0) e = q0.pop_front();
      check_beat(0, a, len, e);
    end
    if (v1) begin
      a = {sop1, eop1, chan1, bin1, mag1, dph1};
      len = q1.size(); e = '0;
      if (len != 0) e = q1.pop_front();
      check_beat(1, a, len, e);
    end
    if (cyc == zero_chk_at) begin
      n_cmp += 2;
      if ({v0, sop0, eop0, chan0, bin0, mag0, dph0, err0} !== '0) begin
        n_bad++;
        $display("FAIL out0_reset_zero: got bin %0d mag %0d chan %0d valid %0b, required all 0", bin0, mag0, chan0, v0);
      end
      if ({v1, sop1, eop1, chan1, bin1, mag1, dph1, err1} !== '0) begin
        n_bad++;
        $display("FAIL out1_reset_zero: got bin %0d mag %0d chan %0d valid %0b, required all 0", bin1, mag1, chan1, v1);
      end
    end
    if (cyc == err_chk_at) begin
      n_cmp++;
      if (err_cnt0 != err_chk_exp) begin
        n_bad++;
        $display("FAIL error_pulses: got %0d cycles of error, required %0d", err_cnt0, err_chk_exp);
      end
    end
    if (cyc == end_chk_at) begin
      n_cmp += 2;
      if (q0.size() + q1.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d/%0d beats outstanding, required 0/0", q0.size(), q1.size());
      end
      if (err_cnt0 != 1 || err_cnt1 != 0) begin
        n_bad++;
        $display("FAIL error_total: got %0d/%0d, required 1/0", err_cnt0, err_cnt1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1; zero_chk_at = cyc;
    repeat (2) @(posedge clk); #1; reset = 1'b0;

    // Basic set: common peak bin, distinct phases.
    push(0, 0, 100, 1000, 0); push(0, 1, 100, 1000, 2000); push(0, 2, 100, 1000, -3000);
    full(100, 1000, 1000,   -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, 3000,   -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, -2000,  -1, 0, 0, -1, 0, 0, 0);

    // Phase wrap in both directions.
    push(0, 0, 100, 1000, 0); push(0, 1, 100, 1000, 1472); push(0, 2, 100, 1000, 0);
    full(100, 1000, 25000,  -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, -25000, -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, 25000,  -1, 0, 0, -1, 0, 0, 0);
    push(0, 0, 100, 1000, 0); push(0, 1, 100, 1000, -1472); push(0, 2, 100, 1000, 0);
    full(100, 1000, -25000, -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, 25000,  -1, 0, 0, -1, 0, 0, 0);
    full(100, 1000, -25000, -1, 0, 0, -1, 0, 0, 0);

    // Window excludes bin 0; tie between bins 50 and 80 goes to 50.
    push(0, 0, 50, 500, 0); push(0, 1, 50, 500, 222); push(0, 2, 50, 500, -555);
    full(0, 16777216, 5000, 50, 500, 111,  80, 500, 999, 0);
    full(0, 16777216, 5000, 50, 500, 333,  80, 500, 999, 0);
    full(0, 16777216, 5000, 50, 500, -444, 80, 500, 999, 0);

    // Early eop on channel 1: one error pulse, set dropped.
    full(100, 1000, 0, -1, 0, 0, -1, 0, 0, 0);
    send_frame(500, 500, 100, 1000, 0, -1, 0, 0, -1, 0, 0, 0);
    repeat (4) @(posedge clk); #1; err_chk_exp = 1; err_chk_at = cyc;
    push(0, 0, 200, 700, 0); push(0, 1, 200, 700, 500); push(0, 2, 200, 700, -200);
    full(200, 700, 100,  -1, 0, 0, -1, 0, 0, 0);
    full(200, 700, 600,  -1, 0, 0, -1, 0, 0, 0);
    full(200, 700, -100, -1, 0, 0, -1, 0, 0, 0);
    repeat (10) @(posedge clk); #1;

    // MODE 1: channels 1..2 sampled at channel 0's bin.
    sel_m1 = 1'b1;
    push(1, 0, 100, 1000, 0); push(1, 1, 100, 300, 2500); push(1, 2, 100, 50, -2500);
    full(100, 1000, 1500, -1, 0, 0, -1, 0, 0, 0);
    full(200, 900, 0, 100, 300, 4000, -1, 0, 0, 0);
    full(100, 50, -1000, 300, 2000, 0, -1, 0, 0, 0);
    repeat (10) @(posedge clk); #1;
    sel_m1 = 1'b0;

    // Reset in the middle of channel 1.
    full(100, 1000, 0, -1, 0, 0, -1, 0, 0, 0);
    send_frame(999, -1, 100, 1000, 0, -1, 0, 0, -1, 0, 0, 0);
    reset = 1'b1; zero_chk_at = cyc;
    repeat (2) @(posedge clk); #1; reset = 1'b0;

    // Full set with input gaps; window edges and large wraps.
    push(0, 0, 1, 1234, 0); push(0, 1, 300, 1234, 12528); push(0, 2, 1023, 5000, -19472);
    full(0, 99999, 5, 1, 1234, -32000, -1, 0, 0, 25);
    full(300, 1234, 32000, -1, 0, 0, -1, 0, 0, 25);
    full(1023, 5000, 0, 1024, 9000, 0, -1, 0, 0, 25);

    repeat (10) @(posedge clk); #1; end_chk_at = cyc;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
